// File: rtl/vga_key_pkg.sv
// Shared constants and types for the VGA key front end.
// Covers the debounce and long-press timing, the display-mode codes and the mode FSM states.
package vga_key_pkg;

  // Cycle counts at a 50 MHz system clock: 20 ms debounce, 1 s long press.
  localparam int DEB_CYC_50M  = 1_000_000;
  localparam int LONG_CYC_50M = 50_000_000;

  localparam int MODE_COLORBAR = 0;
  localparam int MODE_CLOCK    = 1;
  localparam int MODE_PONG     = 2;
  localparam int MODE_TEXT     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } mode_state_e;

endpackage

// File: rtl/key_debounce.sv
// Single button channel: a 2-flop synchroniser, a debounce counter and a hold counter.
// Produces the debounced level and registered press, release and long-press pulses.
module key_debounce
  import vga_key_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_50M,
  parameter int LONG_CYC = LONG_CYC_50M
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DW = $clog2(DEB_CYC);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] LONG_V   = HW'(LONG_CYC);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic [DW-1:0] deb_q;
  logic [HW-1:0] hold_q;
  logic          toggle;

  // The level flips on the cycle the mismatch has been seen for DEB_CYC cycles in a row.
  assign toggle = (sync_q[1] != level_q) && (deb_q == DEB_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b00;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      deb_q     <= '0;
      hold_q    <= '0;
    end else begin
      sync_q    <= {sync_q[0], ~key_n_i};
      press_q   <= toggle && !level_q;
      release_q <= toggle && level_q;
      long_q    <= 1'b0;

      if (sync_q[1] == level_q) begin
        deb_q <= '0;
      end else if (toggle) begin
        deb_q   <= '0;
        level_q <= ~level_q;
      end else begin
        deb_q <= deb_q + DW'(1);
      end

      // A release landing on the long-press cycle wins, so the hold counts as short.
      if (toggle) begin
        hold_q <= '0;
      end else if (level_q && (hold_q != LONG_V)) begin
        hold_q <= hold_q + HW'(1);
        if (hold_q == LONG_V - HW'(1)) long_q <= 1'b1;
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Multi-key front end plus the display-mode register for the VGA top.
// A short press of MODE_KEY steps the mode; a long press returns it to mode 0.
module key_mode_ctrl
  import vga_key_pkg::*;
#(
  parameter int NUM_KEYS  = 3,
  parameter int DEB_CYC   = DEB_CYC_50M,
  parameter int LONG_CYC  = LONG_CYC_50M,
  parameter int NUM_MODES = 4,
  parameter int MODE_KEY  = 0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [NUM_KEYS-1:0]          key_in,
  output logic [NUM_KEYS-1:0]          key_level,
  output logic [NUM_KEYS-1:0]          key_press,
  output logic [NUM_KEYS-1:0]          key_release,
  output logic [NUM_KEYS-1:0]          key_long,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         mode_chg,
  output mode_state_e                  mode_state
);

  localparam int MW = $clog2(NUM_MODES);
  localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0] MODE_HOME = MW'(MODE_COLORBAR);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEB_CYC (DEB_CYC),
      .LONG_CYC(LONG_CYC)
    ) u_key (
      .clk_i    (sys_clk),
      .rst_i    (sys_rst),
      .key_n_i  (key_in[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
  end

  mode_state_e   state_q;
  logic [MW-1:0] mode_q;
  logic          mode_chg_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_HOME;
      mode_chg_q <= 1'b0;
    end else begin
      mode_chg_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (key_press[MODE_KEY]) state_q <= ST_HELD;
        ST_HELD: begin
          if (key_release[MODE_KEY]) begin
            state_q    <= ST_IDLE;
            mode_q     <= (mode_q == MODE_LAST) ? MODE_HOME : mode_q + MW'(1);
            mode_chg_q <= 1'b1;
          end else if (key_long[MODE_KEY]) begin
            state_q    <= ST_LONG;
            mode_q     <= MODE_HOME;
            mode_chg_q <= (mode_q != MODE_HOME);
          end
        end
        ST_LONG: if (key_release[MODE_KEY]) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode       = mode_q;
  assign mode_chg   = mode_chg_q;
  assign mode_state = state_q;

endmodule
